// File: rtl/led_ws2812_serializer_if.sv
// Interface for the WS2812 serializer.
// It groups the enable level, the eight GRB colour words and the three status outputs.
// The master drives the colours and enable; the slave is the serializer.
interface led_ws2812_serializer_if;
  logic        enable;
  logic [23:0] led_0;
  logic [23:0] led_1;
  logic [23:0] led_2;
  logic [23:0] led_3;
  logic [23:0] led_4;
  logic [23:0] led_5;
  logic [23:0] led_6;
  logic [23:0] led_7;
  logic        led_out;
  logic        busy;
  logic        frame_done;

  modport master (
    output enable, led_0, led_1, led_2, led_3, led_4, led_5, led_6, led_7,
    input  led_out, busy, frame_done
  );

  modport slave (
    input  enable, led_0, led_1, led_2, led_3, led_4, led_5, led_6, led_7,
    output led_out, busy, frame_done
  );
endinterface

// File: rtl/led_ws2812_serializer.sv
// WS2812 one-wire serializer for a chain of eight GRB LEDs.
//
// The eight colour words are snapshotted together. They are sent MSB-first with
// led_0 first, and each frame is followed by a low latch period. Frames repeat
// while enable is high.
//
// Optional macro LED_CHANGE_ONLY_EN: when it is defined, a new frame starts only
// in two cases. Either nothing has been sent since reset, or the live colours
// differ from the last frame that was sent.
module led_ws2812_serializer #(
  parameter int BIT_CYC   = 105,
  parameter int T0H_CYC   = 30,
  parameter int T1H_CYC   = 67,
  parameter int RESET_CYC = 25200,
  parameter int CNT_W     = 16
) (
  input  logic                     dataclk,
  input  logic                     reset,
  led_ws2812_serializer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BIT   = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int               FRAME_BITS = 192;
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0] T0H        = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T1H        = CNT_W'(T1H_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [7:0]       IDX_LAST   = 8'(FRAME_BITS - 1);

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]            thx_d;
  logic [7:0]                  idx_q, idx_d;
  logic [FRAME_BITS-1:0]       shift_q, shift_d;
  logic [FRAME_BITS-1:0]       live_w;
  logic                        led_out_q, led_out_d;
  logic                        frame_done_q, frame_done_d;
  // Set while the latch was entered from reset; that latch must not report a frame.
  logic                        from_rst_q, from_rst_d;
  logic                        start_ok;

  assign live_w = {bus.led_0, bus.led_1, bus.led_2, bus.led_3,
                   bus.led_4, bus.led_5, bus.led_6, bus.led_7};

`ifdef LED_CHANGE_ONLY_EN
  logic [FRAME_BITS-1:0]       last_sent_q, last_sent_d;
  logic                        sent_valid_q, sent_valid_d;
  assign start_ok = !sent_valid_q || (live_w != last_sent_q);
`else
  assign start_ok = 1'b1;
`endif

  // Next-state and output decode. led_out is computed from the next state so the registered pin is glitch-free.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    from_rst_d   = from_rst_q;
    frame_done_d = 1'b0;
`ifdef LED_CHANGE_ONLY_EN
    last_sent_d  = last_sent_q;
    sent_valid_d = sent_valid_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.enable && start_ok) state_d = LOAD;
      end
      LOAD: begin
        shift_d = live_w;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = BIT;
`ifdef LED_CHANGE_ONLY_EN
        last_sent_d  = live_w;
        sent_valid_d = 1'b1;
`endif
      end
      BIT: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
          if (idx_q == IDX_LAST) state_d = LATCH;
          else                   idx_d   = idx_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LATCH: begin
        if (cnt_q == RESET_LAST) begin
          cnt_d        = '0;
          state_d      = IDLE;
          frame_done_d = !from_rst_q;
          from_rst_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = LATCH;
    endcase
    thx_d     = shift_d[FRAME_BITS-1] ? T1H : T0H;
    led_out_d = (state_d == BIT) && (cnt_d < thx_d);
  end

  // State register. Reset drops the line low at once and forces a full latch period.
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      state_q      <= LATCH;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      led_out_q    <= 1'b0;
      frame_done_q <= 1'b0;
      from_rst_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      led_out_q    <= led_out_d;
      frame_done_q <= frame_done_d;
      from_rst_q   <= from_rst_d;
    end
  end

`ifdef LED_CHANGE_ONLY_EN
  // Remembers the last transmitted snapshot so identical colours produce no traffic.
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      last_sent_q  <= '0;
      sent_valid_q <= 1'b0;
    end else begin
      last_sent_q  <= last_sent_d;
      sent_valid_q <= sent_valid_d;
    end
  end
`endif

  assign bus.led_out    = led_out_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_led_ws2812_serializer.sv
// Self-checking bench for led_ws2812_serializer.
// It uses shortened timing parameters. The serial line is decoded back into bits
// by measuring high times over fixed bit windows. The decoded frames are compared
// with the colour snapshot that the bench applied.
module tb_led_ws2812_serializer;
  localparam int BIT   = 10;
  localparam int T0H   = 3;
  localparam int T1H   = 7;
  localparam int RST   = 20;
  localparam int FRAME = 2 + 192 * BIT + RST;

  typedef struct {
    logic [191:0] leds;
    int           exp_ones;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_ws2812_serializer_if bus();

  led_ws2812_serializer #(
    .BIT_CYC(BIT), .T0H_CYC(T0H), .T1H_CYC(T1H), .RESET_CYC(RST), .CNT_W(16)
  ) dut (
    .dataclk(clk),
    .reset(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [191:0] act, input logic [191:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_leds(input logic [191:0] v);
    bus.led_0 = v[191:168];
    bus.led_1 = v[167:144];
    bus.led_2 = v[143:120];
    bus.led_3 = v[119:96];
    bus.led_4 = v[95:72];
    bus.led_5 = v[71:48];
    bus.led_6 = v[47:24];
    bus.led_7 = v[23:0];
  endtask

  // Counts samples until the line first goes high, along with frame_done pulses and busy-low samples seen on the way.
  task automatic wait_first_high(output int n, output int fd, output int busy_low);
    n = 0; fd = 0; busy_low = 0;
    while (bus.led_out !== 1'b1 && n < 4 * FRAME) begin
      tick();
      n++;
      if (bus.frame_done === 1'b1) fd++;
      if (bus.busy !== 1'b1) busy_low++;
    end
    if (bus.led_out !== 1'b1) check("first_high_seen", int'(bus.led_out === 1'b1), 1);
  endtask

  // Watches the line for a span of idle cycles and expects no activity at all.
  task automatic idle_hold(input int len, input string name);
    int act;
    act = 0;
    for (int i = 0; i < len; i++) begin
      tick();
      if (bus.busy !== 1'b0 || bus.led_out !== 1'b0 || bus.frame_done !== 1'b0) act++;
    end
    check(name, act, 0);
  endtask

  // Decodes one frame starting at the first high sample, then checks the latch and the frame_done pulse.
  // act: 0 none, 1 change led_3 to act_val, 2 drop enable, 3 assert reset (frame aborted)
  task automatic capture_frame(input logic [191:0] exp, input int act, input int act_bit,
                               input logic [23:0] act_val, output logic [191:0] bits,
                               output bit aborted);
    int bad, hc, lo, bad_l;
    bit lowseen, shape_ok;
    bad = 0; bits = '0; aborted = 1'b0;
    for (int b = 0; b < 192; b++) begin
      hc = 0; lowseen = 1'b0; shape_ok = 1'b1;
      for (int c = 0; c < BIT; c++) begin
        if (b > 0 || c > 0) tick();
        if (c == 0 && b == act_bit) begin
          if (act == 1) bus.led_3 = act_val;
          if (act == 2) bus.enable = 1'b0;
          if (act == 3) begin
            rst = 1'b1;
            #1;
            check("reset_led_out_low", int'(bus.led_out), 0);
            check("reset_busy_high", int'(bus.busy), 1);
            check("reset_no_done", int'(bus.frame_done), 0);
            aborted = 1'b1;
            return;
          end
        end
        if (bus.led_out === 1'b1) begin
          if (lowseen) shape_ok = 1'b0;
          else         hc++;
        end else begin
          lowseen = 1'b1;
        end
        if (bus.busy !== 1'b1) shape_ok = 1'b0;
      end
      if (!shape_ok || (hc != T0H && hc != T1H)) bad++;
      bits[191 - b] = (hc == T1H);
    end
    check("bit_shape_errors", bad, 0);
    check_vec("frame_bits", bits, exp);
    lo = 0; bad_l = 0;
    tick();
    while (bus.frame_done !== 1'b1 && lo < RST + 10) begin
      if (bus.led_out !== 1'b0 || bus.busy !== 1'b1) bad_l++;
      lo++;
      tick();
    end
    check("latch_length", lo, RST);
    check("latch_line_low", bad_l, 0);
    check("done_busy_low", int'(bus.busy), 0);
    if (last_done_cyc >= 0) check("frame_period", cyc - last_done_cyc, FRAME);
    last_done_cyc = cyc;
    $display("frame exp=%h ones=%0d latch=%0d", exp, $countones(bits), lo);
  endtask

  vec_t         tbl[8];
  int           n, fd, bl;
  logic [191:0] bits, v, v2;
  bit           ab;

  initial begin
    tbl[0].leds = {8{24'h700000}};      tbl[0].exp_ones = 24;
    tbl[1].leds = '0;                   tbl[1].exp_ones = 0;
    tbl[2].leds = {8{24'hffffff}};      tbl[2].exp_ones = 192;
    tbl[3].leds = {24'h800001, {7{24'h000000}}}; tbl[3].exp_ones = 2;
    tbl[4].leds = {8{24'h000070}};      tbl[4].exp_ones = 24;
    for (int i = 5; i < 8; i++) begin
      tbl[i].leds = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      tbl[i].exp_ones = $countones(tbl[i].leds);
    end

    // Reset with enable high: a full latch must pass before the first frame.
    bus.enable = 1'b1;
    set_leds(tbl[0].leds);
    repeat (3) tick();
    check("rst_led_out", int'(bus.led_out), 0);
    check("rst_busy", int'(bus.busy), 1);
    check("rst_frame_done", int'(bus.frame_done), 0);
    rst = 1'b0;
    wait_first_high(n, fd, bl);
    check("reset_to_first_high", n, RST + 2);
    check("reset_latch_no_done", fd, 0);
    check("reset_idle_cycles", bl, 1);

    // Table of colour sets, sent back to back.
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        set_leds(tbl[i].leds);
        wait_first_high(n, fd, bl);
        check("gap_to_next_frame", n, 2);
        check("done_single_pulse", fd, 0);
        check("busy_low_between", bl, 0);
      end
      capture_frame(tbl[i].leds, 0, -1, 24'h0, bits, ab);
      check("ones_count", $countones(bits), tbl[i].exp_ones);
    end

    // Change led_3 mid-frame: the current frame keeps the old snapshot.
    v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    v[119:96] = 24'h000070;
    set_leds(v);
    wait_first_high(n, fd, bl);
    check("gap_mid_change", n, 2);
    capture_frame(v, 1, 50, 24'h700000, bits, ab);
    v2 = v;
    v2[119:96] = 24'h700000;
    wait_first_high(n, fd, bl);
    check("gap_after_change", n, 2);
    capture_frame(v2, 0, -1, 24'h0, bits, ab);

    // Drop enable at bit 100: the frame completes, then the block stays idle.
    v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    set_leds(v);
    wait_first_high(n, fd, bl);
    capture_frame(v, 2, 100, 24'h0, bits, ab);
    idle_hold(3 * RST + 50, "idle_after_disable");

    // Re-enable with new colours.
    v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    set_leds(v);
    bus.enable = 1'b1;
    last_done_cyc = -1;
    wait_first_high(n, fd, bl);
    check("reenable_to_high", n, 2);
    capture_frame(v, 0, -1, 24'h0, bits, ab);

    // Reset at bit 80 discards the frame and forces a full latch.
    wait_first_high(n, fd, bl);
    capture_frame(v, 3, 80, 24'h0, bits, ab);
    check("reset_aborted", int'(ab), 1);
    repeat (3) tick();
    rst = 1'b0;
    last_done_cyc = -1;
    wait_first_high(n, fd, bl);
    check("midreset_to_first_high", n, RST + 2);
    check("midreset_no_done", fd, 0);
    capture_frame(v, 0, -1, 24'h0, bits, ab);

`ifdef LED_CHANGE_ONLY_EN
    // Unchanged colours: no further traffic. A change to led_7 gives exactly one frame.
    idle_hold(3 * RST + 50, "no_traffic_same_colours");
    v[23:0] = 24'h303030;
    set_leds(v);
    wait_first_high(n, fd, bl);
    check("change_to_high", n, 2);
    capture_frame(v, 0, -1, 24'h0, bits, ab);
    idle_hold(3 * RST + 50, "single_frame_after_change");
`else
    // Unchanged colours with enable held: frames keep repeating.
    wait_first_high(n, fd, bl);
    check("repeat_gap", n, 2);
    check("repeat_busy_low", bl, 0);
    capture_frame(v, 0, -1, 24'h0, bits, ab);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
